// File: rtl/gray_accel_pkg.sv
// Shared register map, bit positions, luma coefficients and the bus request record
// for the iomem greyscale accelerator.
package gray_accel_pkg;
  localparam logic [5:0] OFF_DATA_IN  = 6'h00;
  localparam logic [5:0] OFF_DATA_OUT = 6'h01;
  localparam logic [5:0] OFF_STATUS   = 6'h02;
  localparam logic [5:0] OFF_CTRL     = 6'h03;

  localparam int ST_IN_FULL   = 0;
  localparam int ST_IN_EMPTY  = 1;
  localparam int ST_OUT_FULL  = 2;
  localparam int ST_OUT_EMPTY = 3;
  localparam int ST_OVF       = 4;
  localparam int ST_UNF       = 5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int KR = 77;
  localparam int KG = 150;
  localparam int KB = 29;

  typedef struct packed {
    logic [5:0]  off;
    logic        wr;
    logic [1:0]  be;
    logic [23:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flush has priority over push and pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign count   = wr_q - rd_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_q == rd_q);
  assign dout    = mem[rd_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/iomem_gray_accel.sv
// picosoc iomem slave: RGB pixels in, 8-bit luma out through a 2-stage multiply/sum
// pipeline; level irq when the output queue reaches a programmable threshold.
module iomem_gray_accel
  import gray_accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          DEPTH     = 16,
  parameter int          CW        = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);
  localparam int AW     = $clog2(DEPTH);
  localparam int STAGES = 2;
  localparam int PW     = CW + 8;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  bus_req_t        req_q;
  logic            ready_q, sel;
  logic            enable_q, irq_en_q, clear_q, ovf_q, unf_q, irq_q;
  logic [7:0]      thresh_q;
  logic [STAGES:1] vld_pipe;
  logic [PW-1:0]   pr_q, pg_q, pb_q, sum;
  logic [7:0]      y_q;
  logic [31:0]     rdata_d;

  logic            in_full, in_empty, out_full, out_empty;
  logic [AW:0]     in_count, out_count;
  logic [23:0]     in_dout;
  logic [7:0]      out_dout;
  logic            wr_data_in, rd_data_out, wr_ctrl, pop;
  logic [AW+1:0]   occ;
  logic            unused;

  assign unused = ^{iomem_addr[1:0], iomem_wdata[31:24]};

  // One request is captured per selection; the ack cycle then acts on req_q.
  assign sel = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]) && !ready_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      req_q   <= '0;
    end else begin
      ready_q <= sel;
      if (sel) req_q <= '{off: iomem_addr[7:2], wr: |iomem_wstrb,
                          be: iomem_wstrb[1:0], wdata: iomem_wdata[23:0]};
    end
  end

  assign wr_data_in  = ready_q && req_q.wr  && (req_q.off == OFF_DATA_IN);
  assign rd_data_out = ready_q && !req_q.wr && (req_q.off == OFF_DATA_OUT);
  assign wr_ctrl     = ready_q && req_q.wr  && (req_q.off == OFF_CTRL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      clear_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      clear_q <= wr_ctrl && req_q.be[0] && req_q.wdata[CTRL_CLEAR];
      if (wr_ctrl && req_q.be[0]) begin
        enable_q <= req_q.wdata[CTRL_EN];
        irq_en_q <= req_q.wdata[CTRL_IRQ_EN];
      end
      if (wr_ctrl && req_q.be[1]) thresh_q <= req_q.wdata[15:8];
      if (clear_q) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (wr_data_in && in_full)    ovf_q <= 1'b1;
        if (rd_data_out && out_empty) unf_q <= 1'b1;
      end
      irq_q <= irq_en_q && (thresh_q != 8'd0) && (8'(out_count) >= thresh_q);
    end
  end

  // Reserve an output slot for every pixel in flight so S2 never pushes into a full queue.
  assign occ = (AW+2)'(out_count) + (AW+2)'(vld_pipe[1]) + (AW+2)'(vld_pipe[2]);
  assign pop = enable_q && !in_empty && (occ < DEPTH_W) && !clear_q;
  assign sum = pr_q + pg_q + pb_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      pr_q     <= '0;
      pg_q     <= '0;
      pb_q     <= '0;
      y_q      <= '0;
    end else begin
      vld_pipe <= clear_q ? '0 : {vld_pipe[1], pop};
      pr_q     <= PW'(KR) * PW'(in_dout[23:16]);
      pg_q     <= PW'(KG) * PW'(in_dout[15:8]);
      pb_q     <= PW'(KB) * PW'(in_dout[7:0]);
      y_q      <= sum[PW-1 -: 8];
    end
  end

  sync_fifo #(.WIDTH(24), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .resetn(resetn), .flush(clear_q),
    .push(wr_data_in), .din(req_q.wdata), .pop(pop), .dout(in_dout),
    .full(in_full), .empty(in_empty), .count(in_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .resetn(resetn), .flush(clear_q),
    .push(vld_pipe[2]), .din(y_q), .pop(rd_data_out), .dout(out_dout),
    .full(out_full), .empty(out_empty), .count(out_count)
  );

  // Read data is taken from pre-side-effect state during the ack cycle.
  always_comb begin
    rdata_d = '0;
    if (ready_q && !req_q.wr) begin
      case (req_q.off)
        OFF_DATA_OUT: if (!out_empty) rdata_d[7:0] = out_dout;
        OFF_STATUS: begin
          rdata_d[ST_IN_FULL]   = in_full;
          rdata_d[ST_IN_EMPTY]  = in_empty;
          rdata_d[ST_OUT_FULL]  = out_full;
          rdata_d[ST_OUT_EMPTY] = out_empty;
          rdata_d[ST_OVF]       = ovf_q;
          rdata_d[ST_UNF]       = unf_q;
          rdata_d[15:8]         = 8'(out_count);
          rdata_d[23:16]        = 8'(in_count);
        end
        OFF_CTRL: begin
          rdata_d[CTRL_EN]     = enable_q;
          rdata_d[CTRL_IRQ_EN] = irq_en_q;
          rdata_d[15:8]        = thresh_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_d;
  assign irq         = irq_q;
endmodule

// File: tb/tb_iomem_gray_accel.sv
// Directed bench for iomem_gray_accel: bus handshake, conversion, FIFO limits, irq.
module tb_iomem_gray_accel;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [7:0] A_DIN = 8'h00, A_DOUT = 8'h04, A_STAT = 8'h08, A_CTRL = 8'h0C;

  logic        clk = 1'b0, resetn = 1'b0, iomem_valid = 1'b0;
  logic        iomem_ready, irq;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0, iomem_wdata = '0, iomem_rdata;
  logic [31:0] d;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  iomem_gray_accel #(.BASE_ADDR(BASE), .DEPTH(16), .CW(8)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called just after a negedge; returns at the negedge inside the ack cycle.
  task automatic bus(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd,
                     output logic [31:0] rd);
    int n = 0;
    iomem_valid = 1'b1; iomem_addr = BASE | 32'(off); iomem_wstrb = strb; iomem_wdata = wd;
    do begin @(negedge clk); n++; end while (!iomem_ready && n < 20);
    if (!iomem_ready) chk("bus_timeout", 32'(iomem_ready), 32'd1);
    rd = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = '0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] t;
    bus(off, s, wd, t);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    bus(off, 4'h0, 32'h0, r);
  endtask

  function automatic logic [7:0] luma(input logic [23:0] p);
    logic [15:0] s;
    s = 16'd77 * p[23:16] + 16'd150 * p[15:8] + 16'd29 * p[7:0];
    return s[15:8];
  endfunction

  function automatic logic [23:0] px(input int i);
    return {8'(i * 16 + 3), 8'(255 - i * 7), 8'(i * 11)};
  endfunction

  initial begin
    // reset held while a request is pending
    iomem_valid = 1'b1; iomem_addr = BASE | 32'h8;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(iomem_ready), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
    iomem_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    rd(A_STAT, d);   chk("rst_status", d, 32'h0000_000A);
    rd(8'h10, d);    chk("unmapped_rd", d, 32'h0);

    // colour conversion and latency
    wr(A_CTRL, 32'h1, 4'h1);
    wr(A_DIN, 32'h00FF_FFFF, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_empty_%0d", k), 32'(dut.out_empty), (k < 4) ? 32'd1 : 32'd0);
    end
    wr(A_DIN, 32'h00FF_0000, 4'hF);
    wr(A_DIN, 32'h0000_FF00, 4'hF);
    wr(A_DIN, 32'h0000_00FF, 4'hF);
    repeat (6) @(negedge clk);
    rd(A_DOUT, d); chk("white", d, 32'hFF);
    rd(A_DOUT, d); chk("red", d, 32'h4C);
    rd(A_DOUT, d); chk("green", d, 32'h95);
    rd(A_DOUT, d); chk("blue", d, 32'h1C);

    // underflow
    rd(A_DOUT, d);  chk("unf_data", d, 32'h0);
    rd(A_STAT, d);  chk("unf_status", d, 32'h0000_002A);

    // overflow with the pipe disabled
    wr(A_CTRL, 32'h4, 4'h1);
    rd(A_STAT, d);  chk("clr_status", d, 32'h0000_000A);
    for (int i = 0; i < 17; i++) wr(A_DIN, {8'h0, px(i)}, 4'hF);
    rd(A_STAT, d);  chk("ovf_status", d, 32'h0010_0019);
    wr(A_CTRL, 32'h1, 4'h1);
    repeat (30) @(negedge clk);
    rd(A_STAT, d);  chk("ovf_drained_in", d, 32'h0000_1016);
    for (int i = 0; i < 16; i++) begin
      rd(A_DOUT, d); chk($sformatf("ovf_res%0d", i), d, {24'h0, luma(px(i))});
    end
    rd(A_STAT, d);  chk("ovf_after", d, 32'h0000_001A);
    wr(A_CTRL, 32'h4, 4'h1);
    rd(A_STAT, d);  chk("ovf_cleared", d, 32'h0000_000A);

    // interrupt threshold
    wr(A_CTRL, 32'h0000_0403, 4'h3);
    rd(A_CTRL, d);  chk("ctrl_rd", d, 32'h0000_0403);
    for (int i = 0; i < 3; i++) wr(A_DIN, {8'h0, px(i + 20)}, 4'hF);
    repeat (6) @(negedge clk);
    chk("irq_below", 32'(irq), 32'd0);
    wr(A_DIN, {8'h0, px(23)}, 4'hF);
    repeat (6) @(negedge clk);
    chk("irq_at", 32'(irq), 32'd1);
    rd(A_DOUT, d);  chk("irq_res0", d, {24'h0, luma(px(20))});
    @(negedge clk); chk("irq_hold", 32'(irq), 32'd1);
    @(negedge clk); chk("irq_drop", 32'(irq), 32'd0);
    for (int i = 1; i < 4; i++) begin
      rd(A_DOUT, d); chk($sformatf("irq_res%0d", i), d, {24'h0, luma(px(i + 20))});
    end

    // back-pressure: output queue fills, input holds the rest
    wr(A_CTRL, 32'h1, 4'h1);
    for (int i = 0; i < 20; i++) wr(A_DIN, {8'h0, px(i + 30)}, 4'hF);
    repeat (20) @(negedge clk);
    rd(A_STAT, d);  chk("bp_status", d, 32'h0004_1004);
    for (int i = 0; i < 20; i++) begin
      rd(A_DOUT, d); chk($sformatf("bp_res%0d", i), d, {24'h0, luma(px(i + 30))});
    end
    rd(A_STAT, d);  chk("bp_empty", d, 32'h0000_000A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
